// File: rtl/player_pkg.sv
// Purpose: shared types and default tuning constants for the player-motion engine.
// Latency: n/a (declarations only).
// Backpressure: n/a; no flow control anywhere in this block, every tick is consumed.
package player_pkg;

    // Player state. The numeric codes are visible on the pstate output.
    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2,
        ST_DEAD   = 2'd3
    } pstate_t;

    // Vertical speed in px/tick; wide enough for the jump launch speed.
    typedef logic [3:0] vel_t;

    localparam int X_START_DEF     = 320;
    localparam int X_MIN_DEF       = 10;
    localparam int X_MAX_DEF       = 629;
    localparam int Y_MIN_DEF       = 10;
    localparam int FLOOR_Y_DEF     = 400;
    localparam int Y_BOTTOM_DEF    = 479;
    localparam int STEP_DEF        = 2;
    localparam int JUMP_V_DEF      = 12;
    localparam int MAX_FALL_DEF    = 8;
    localparam int DEAD_CYCLES_DEF = 64;

endpackage

// File: rtl/player_motion_if.sv
// Purpose: bundles the button/level inputs and the position/status outputs of player_motion.
// Latency: n/a (wiring only).
// Backpressure: none; the engine samples the inputs on every movement tick.
// Ports: up/down/left/right, floor_gap, death in; x_pos, y_pos, airborne, dead, fell, pstate out.
interface player_motion_if;
    import player_pkg::*;

    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       floor_gap;
    logic       death;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       airborne;
    logic       dead;
    logic       fell;
    logic [1:0] pstate;

    // Driver side: buttons and level signals out, position and status in.
    modport master (
        output up, down, left, right, floor_gap, death,
        input  x_pos, y_pos, airborne, dead, fell, pstate
    );

    // Engine side.
    modport slave (
        input  up, down, left, right, floor_gap, death,
        output x_pos, y_pos, airborne, dead, fell, pstate
    );

endinterface

// File: rtl/btn_edge.sv
// Purpose: rising-edge detector for a button that is already synchronous to clk.
// Latency: o_rise is combinational from i_btn against last tick's registered value.
// Backpressure: none.
// Ports: clk, rst (sync, active-high), i_btn in; o_rise out.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/player_motion.sv
// Purpose: turns direction buttons into clamped player x/y with jump arc, gravity, pits and respawn.
// Latency: 1 tick; every output is registered or decoded from registered state.
// Backpressure: none; one position update per clk edge, inputs are never stalled.
// Ports: clk, rst (sync, active-high); io_pm (slave) carries buttons, floor_gap, death in
//        and x_pos, y_pos, airborne, dead, fell, pstate out.
module player_motion
    import player_pkg::*;
#(
    parameter int X_START     = X_START_DEF,
    parameter int X_MIN       = X_MIN_DEF,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MIN       = Y_MIN_DEF,
    parameter int FLOOR_Y     = FLOOR_Y_DEF,
    parameter int Y_BOTTOM    = Y_BOTTOM_DEF,
    parameter int STEP        = STEP_DEF,
    parameter int JUMP_V      = JUMP_V_DEF,
    parameter int MAX_FALL    = MAX_FALL_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    player_motion_if.slave   io_pm
);

    localparam int CNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);

    // 10-bit register forms of the screen limits.
    localparam logic [9:0] P_X_START = 10'(X_START);
    localparam logic [9:0] P_X_MIN   = 10'(X_MIN);
    localparam logic [9:0] P_X_MAX   = 10'(X_MAX);
    localparam logic [9:0] P_Y_MIN   = 10'(Y_MIN);
    localparam logic [9:0] P_FLOOR   = 10'(FLOOR_Y);
    localparam logic [9:0] P_BOTTOM  = 10'(Y_BOTTOM);

    // 11-bit signed forms so an under/overshoot is compared before it can wrap.
    localparam logic signed [10:0] S_STEP   = 11'(STEP);
    localparam logic signed [10:0] S_X_MIN  = 11'(X_MIN);
    localparam logic signed [10:0] S_X_MAX  = 11'(X_MAX);
    localparam logic signed [10:0] S_Y_MIN  = 11'(Y_MIN);
    localparam logic signed [10:0] S_FLOOR  = 11'(FLOOR_Y);
    localparam logic signed [10:0] S_BOTTOM = 11'(Y_BOTTOM);

    localparam vel_t P_JUMP_V   = vel_t'(JUMP_V);
    localparam vel_t P_MAX_FALL = vel_t'(MAX_FALL);
    localparam vel_t P_VEL_ONE  = vel_t'(1);

    pstate_t          r_state, w_state_nxt;
    vel_t             r_vel, w_vel_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [9:0]       r_x, w_x_nxt;
    logic [9:0]       r_y, w_y_nxt;
    logic             r_fell, w_fell_nxt;

    logic              w_up_rise;
    logic signed [10:0] w_x_s, w_x_dec, w_x_inc;
    logic signed [10:0] w_y_s, w_vel_s, w_y_rise, w_y_fall;
    logic [9:0]        w_x_walk;

    btn_edge u_up_edge (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (io_pm.up),
        .o_rise (w_up_rise)
    );

    assign w_x_s    = signed'({1'b0, r_x});
    assign w_x_dec  = w_x_s - S_STEP;
    assign w_x_inc  = w_x_s + S_STEP;
    assign w_y_s    = signed'({1'b0, r_y});
    assign w_vel_s  = signed'({7'd0, r_vel});
    assign w_y_rise = w_y_s - w_vel_s;
    assign w_y_fall = w_y_s + w_vel_s;

    // Walking: opposing buttons cancel; result is clamped to the playfield.
    always_comb begin
        w_x_walk = r_x;
        if (io_pm.left && !io_pm.right) begin
            w_x_walk = (w_x_dec < S_X_MIN) ? P_X_MIN : w_x_dec[9:0];
        end else if (io_pm.right && !io_pm.left) begin
            w_x_walk = (w_x_inc > S_X_MAX) ? P_X_MAX : w_x_inc[9:0];
        end
    end

    // Next-state logic. DEAD ignores every input except rst; a kill request
    // from any live state freezes the position for that tick.
    always_comb begin
        w_state_nxt = r_state;
        w_vel_nxt   = r_vel;
        w_cnt_nxt   = '0;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_fell_nxt  = 1'b0;

        if (r_state == ST_DEAD) begin
            if (r_cnt == CNT_LAST) begin
                w_state_nxt = ST_GROUND;
                w_x_nxt     = P_X_START;
                w_y_nxt     = P_FLOOR;
                w_vel_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (io_pm.death) begin
            w_state_nxt = ST_DEAD;
            w_vel_nxt   = '0;
        end else begin
            w_x_nxt = w_x_walk;
            case (r_state)
                ST_GROUND: begin
                    if (w_up_rise) begin
                        w_state_nxt = ST_RISE;
                        w_vel_nxt   = P_JUMP_V;
                    end else if (io_pm.floor_gap) begin
                        w_state_nxt = ST_FALL;
                        w_vel_nxt   = P_VEL_ONE;
                    end
                end
                ST_RISE: begin
                    if (io_pm.down) begin
                        // Jump cancelled: start falling from where we are.
                        w_state_nxt = ST_FALL;
                        w_vel_nxt   = P_VEL_ONE;
                    end else if (w_y_rise < S_Y_MIN) begin
                        w_y_nxt     = P_Y_MIN;
                        w_state_nxt = ST_FALL;
                        w_vel_nxt   = P_VEL_ONE;
                    end else begin
                        w_y_nxt = w_y_rise[9:0];
                        if (r_vel == P_VEL_ONE) begin
                            // Apex reached this tick.
                            w_state_nxt = ST_FALL;
                            w_vel_nxt   = P_VEL_ONE;
                        end else begin
                            w_vel_nxt = r_vel - 1'b1;
                        end
                    end
                end
                ST_FALL: begin
                    if (w_y_fall >= S_BOTTOM) begin
                        w_y_nxt     = P_BOTTOM;
                        w_fell_nxt  = 1'b1;
                        w_state_nxt = ST_DEAD;
                        w_vel_nxt   = '0;
                    end else if (!io_pm.floor_gap && (w_y_s <= S_FLOOR) && (w_y_fall >= S_FLOOR)) begin
                        // Only lands when crossing the floor from above; a
                        // player already below floor level is inside a pit.
                        w_y_nxt     = P_FLOOR;
                        w_state_nxt = ST_GROUND;
                        w_vel_nxt   = '0;
                    end else begin
                        w_y_nxt   = w_y_fall[9:0];
                        w_vel_nxt = (r_vel >= P_MAX_FALL) ? P_MAX_FALL : r_vel + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_GROUND;
            r_vel   <= '0;
            r_cnt   <= '0;
            r_x     <= P_X_START;
            r_y     <= P_FLOOR;
            r_fell  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vel   <= w_vel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_fell  <= w_fell_nxt;
        end
    end

    assign io_pm.x_pos    = r_x;
    assign io_pm.y_pos    = r_y;
    assign io_pm.fell     = r_fell;
    assign io_pm.pstate   = r_state;
    assign io_pm.airborne = (r_state == ST_RISE) || (r_state == ST_FALL);
    assign io_pm.dead     = (r_state == ST_DEAD);

endmodule

// File: tb/tb_player_motion.sv
// Purpose: self-checking bench for player_motion (default build plus a low-ceiling build).
// Latency: expects each tick's effect on the outputs right after that edge.
// Backpressure: n/a.
module tb_player_motion;

    localparam int GND = 0;
    localparam int RIS = 1;
    localparam int FAL = 2;
    localparam int DED = 3;

    typedef struct packed {
        int x;
        int y;
        int st;
        int vel;
        int cnt;
        bit upq;
        bit fell;
    } mst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic floor_gap = 1'b0, death = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    mst_t m, mc;

    player_motion_if u_if ();
    player_motion_if u_if_c ();

    assign u_if.up          = up;
    assign u_if.down        = down;
    assign u_if.left        = left;
    assign u_if.right       = right;
    assign u_if.floor_gap   = floor_gap;
    assign u_if.death       = death;
    assign u_if_c.up        = up;
    assign u_if_c.down      = down;
    assign u_if_c.left      = left;
    assign u_if_c.right     = right;
    assign u_if_c.floor_gap = floor_gap;
    assign u_if_c.death     = death;

    player_motion u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_pm (u_if)
    );

    player_motion #(.Y_MIN(350)) u_dut_c (
        .clk   (clk),
        .rst   (rst),
        .io_pm (u_if_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: one movement tick, straight from the game rules.
    function automatic mst_t step(input mst_t s, input int ymin, input bit r, input bit u,
                                  input bit d, input bit l, input bit rt, input bit g, input bit dth);
        mst_t n;
        int   ny;
        n      = s;
        n.fell = 1'b0;
        n.upq  = u;
        n.cnt  = 0;
        if (r) begin
            n.x = 320; n.y = 400; n.st = GND; n.vel = 0; n.upq = 1'b0;
            return n;
        end
        if (s.st == DED) begin
            if (s.cnt == 63) begin
                n.x = 320; n.y = 400; n.st = GND; n.vel = 0;
            end else begin
                n.cnt = s.cnt + 1;
            end
            return n;
        end
        if (dth) begin
            n.st = DED; n.vel = 0;
            return n;
        end
        if (l && !rt) n.x = (s.x - 2 < 10) ? 10 : s.x - 2;
        else if (rt && !l) n.x = (s.x + 2 > 629) ? 629 : s.x + 2;
        case (s.st)
            GND: begin
                if (u && !s.upq) begin n.st = RIS; n.vel = 12; end
                else if (g) begin n.st = FAL; n.vel = 1; end
            end
            RIS: begin
                if (d) begin n.st = FAL; n.vel = 1; end
                else if (s.y - s.vel < ymin) begin n.y = ymin; n.st = FAL; n.vel = 1; end
                else begin
                    n.y = s.y - s.vel;
                    if (s.vel == 1) begin n.st = FAL; n.vel = 1; end
                    else n.vel = s.vel - 1;
                end
            end
            FAL: begin
                ny = s.y + s.vel;
                if (ny >= 479) begin n.y = 479; n.fell = 1'b1; n.st = DED; n.vel = 0; end
                else if (!g && s.y <= 400 && ny >= 400) begin n.y = 400; n.st = GND; n.vel = 0; end
                else begin n.y = ny; n.vel = (s.vel + 1 > 8) ? 8 : s.vel + 1; end
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic compare_all();
        chk("x",        int'(u_if.x_pos),    m.x);
        chk("y",        int'(u_if.y_pos),    m.y);
        chk("pstate",   int'(u_if.pstate),   m.st);
        chk("fell",     int'(u_if.fell),     int'(m.fell));
        chk("airborne", int'(u_if.airborne), (m.st == RIS || m.st == FAL) ? 1 : 0);
        chk("dead",     int'(u_if.dead),     (m.st == DED) ? 1 : 0);
        chk("c_x",      int'(u_if_c.x_pos),  mc.x);
        chk("c_y",      int'(u_if_c.y_pos),  mc.y);
        chk("c_pstate", int'(u_if_c.pstate), mc.st);
        chk("c_fell",   int'(u_if_c.fell),   int'(mc.fell));
    endtask

    task automatic tick();
        @(posedge clk);
        m  = step(m,  10,  rst, up, down, left, right, floor_gap, death);
        mc = step(mc, 350, rst, up, down, left, right, floor_gap, death);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        m  = '0;
        mc = '0;

        // Reset, then idle.
        tick();
        chk("rst_x", int'(u_if.x_pos), 320);
        chk("rst_y", int'(u_if.y_pos), 400);
        chk("rst_pstate", int'(u_if.pstate), 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("idle_x", int'(u_if.x_pos), 320);
        chk("idle_air", int'(u_if.airborne), 0);

        // Left clamp, both buttons, walk back.
        left = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            tick();
            if (i == 1) chk("left_first", int'(u_if.x_pos), 318);
            if (i == 155) chk("left_clamp", int'(u_if.x_pos), 10);
        end
        chk("left_hold", int'(u_if.x_pos), 10);
        right = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("both_btn", int'(u_if.x_pos), 10);
        left = 1'b0;
        for (int i = 0; i < 155; i++) tick();
        chk("right_back", int'(u_if.x_pos), 320);
        right = 1'b0;

        // Jump arc, ceiling build, landing, held up does not re-jump.
        up = 1'b1;
        tick();
        chk("jump_start", int'(u_if.pstate), 1);
        up = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) chk("rise1", int'(u_if.y_pos), 388);
            if (i == 5) chk("ceil_y5", int'(u_if_c.y_pos), 350);
            if (i == 6) begin
                chk("ceil_y6", int'(u_if_c.y_pos), 350);
                chk("ceil_fall", int'(u_if_c.pstate), 2);
            end
            if (i == 11) chk("rise_state", int'(u_if.pstate), 1);
        end
        chk("apex", int'(u_if.y_pos), 322);
        chk("apex_fall", int'(u_if.pstate), 2);
        up = 1'b1;
        for (int i = 1; i <= 14; i++) tick();
        chk("land_y", int'(u_if.y_pos), 400);
        chk("land_st", int'(u_if.pstate), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("no_rejump", int'(u_if.pstate), 0);
        up = 1'b0;
        tick();

        // Pit fall to death and respawn.
        floor_gap = 1'b1;
        tick();
        chk("gap_fall", int'(u_if.pstate), 2);
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) chk("pit1", int'(u_if.y_pos), 401);
            if (i == 13) chk("pit_nofell", int'(u_if.fell), 0);
        end
        chk("pit_bottom", int'(u_if.y_pos), 479);
        chk("pit_fell", int'(u_if.fell), 1);
        chk("pit_dead", int'(u_if.dead), 1);
        floor_gap = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 1) chk("fell_pulse", int'(u_if.fell), 0);
            if (i == 63) chk("dead_hold", int'(u_if.dead), 1);
        end
        chk("respawn_x", int'(u_if.x_pos), 320);
        chk("respawn_st", int'(u_if.pstate), 0);

        // Death mid-jump while walking left.
        left = 1'b1;
        up = 1'b1;
        tick();
        up = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_y", int'(u_if.y_pos), 367);
        death = 1'b1;
        tick();
        chk("death_y", int'(u_if.y_pos), 367);
        chk("death_x", int'(u_if.x_pos), 312);
        chk("death_dead", int'(u_if.dead), 1);
        left = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            death = (i <= 4);
            tick();
            if (i == 63) chk("death_hold", int'(u_if.dead), 1);
        end
        chk("death_rx", int'(u_if.x_pos), 320);
        chk("death_ry", int'(u_if.y_pos), 400);

        // Death held through respawn re-enters DEAD.
        death = 1'b1;
        for (int i = 0; i < 65; i++) tick();
        chk("held_respawn", int'(u_if.pstate), 0);
        tick();
        chk("held_redead", int'(u_if.pstate), 3);
        death = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Reset while dead.
        rst = 1'b1;
        tick();
        chk("rst_dead_st", int'(u_if.pstate), 0);
        chk("rst_dead_y", int'(u_if.y_pos), 400);
        rst = 1'b0;

        // Randomised play against the reference.
        for (int i = 0; i < 2000; i++) begin
            rst   = ($urandom_range(0, 255) == 0);
            up    = ($urandom_range(0, 5) == 0);
            down  = ($urandom_range(0, 15) == 0);
            left  = ($urandom_range(0, 2) == 0);
            right = ($urandom_range(0, 2) == 0);
            death = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) floor_gap = ~floor_gap;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/player_motion.md
# player_motion

Player-motion engine for the VGA platformer. It turns the raw direction buttons into the player's `x_pos` and `y_pos` screen coordinates, one update per movement tick, with clamped walking, a fixed-arc jump, gravity, pit falls and a death/respawn sequence. It sits upstream of `level_sm` and the sprite renderer, which consume `x_pos`/`y_pos`. It consumes `death` from `level_sm` and `floor_gap` from the level logic.

## Interface
Parameters:
- `X_START`, 320: respawn/reset x
- `X_MIN`, 10: leftmost x
- `X_MAX`, 629: rightmost x
- `Y_MIN`, 10: ceiling y
- `FLOOR_Y`, 400: floor y, also the reset/respawn y
- `Y_BOTTOM`, 479: screen bottom; reaching it is a fatal fall
- `STEP`, 2: horizontal px per tick
- `JUMP_V`, 12: initial rise velocity, px/tick
- `MAX_FALL`, 8: terminal fall velocity
- `DEAD_CYCLES`, 64: ticks frozen in DEAD before respawn

Ports:
- `clk`, in, 1: movement clock, driven by `DIV_CLK[19]` (move_clk); one tick per edge
- `rst`, in, 1: synchronous, active-high
- `up`, `down`, `left`, `right`, in, 1 each: buttons, already synchronous to `clk`
- `floor_gap`, in, 1: no floor under the player (pit open)
- `death`, in, 1: kill request from `level_sm` (level)
- `x_pos`, `y_pos`, out, 10 each: player position, registered
- `airborne`, out, 1: state is RISE or FALL
- `dead`, out, 1: state is DEAD
- `fell`, out, 1: one-tick pulse when a fall reaches `Y_BOTTOM`
- `pstate`, out, 2: GROUND=0, RISE=1, FALL=2, DEAD=3

## Operation
- **Reset:** `x_pos`=X_START, `y_pos`=FLOOR_Y, state GROUND, vel=0, dead-counter=0, `up_q`=0, `fell`=0, `airborne`=0, `dead`=0.
- **Arithmetic:** all position math uses 11-bit signed intermediates. Clamp before truncating to 10 bits. Never wrap.
- **Horizontal (every state except DEAD):**
  - `left` only: x = max(x−STEP, X_MIN).
  - `right` only: x = min(x+STEP, X_MAX).
  - Both pressed or neither: x unchanged.
- **GROUND:**
  - A rising edge of `up` (`up` & ~`up_q`) → RISE with vel=JUMP_V. Holding `up` does not re-jump.
  - `floor_gap`=1 (and no jump) → FALL with vel=1.
- **RISE:**
  - Each tick: y −= vel, vel −= 1.
  - If y−vel < Y_MIN: y=Y_MIN, → FALL, vel=1.
  - When the applied vel was 1: → FALL, vel=1.
  - `down`=1: → FALL, vel=1, no vertical move that tick.
- **FALL:**
  - Each tick: y_next = y+vel, then vel = min(vel+1, MAX_FALL).
  - Landing requires all of: `floor_gap`=0, pre-move y ≤ FLOOR_Y, and y_next ≥ FLOOR_Y. Then y=FLOOR_Y, → GROUND, vel=0.
  - If pre-move y > FLOOR_Y (player is inside a pit), keep falling regardless of `floor_gap`.
  - If y_next ≥ Y_BOTTOM: y=Y_BOTTOM, `fell`=1 for that tick, → DEAD.
- **DEAD:**
  - Position frozen. Counter counts 0..DEAD_CYCLES−1.
  - On the terminal count: x=X_START, y=FLOOR_Y, → GROUND, counter cleared.
  - `death` is ignored while in DEAD. If `death` is still high after respawn, DEAD is re-entered on the next tick.
- **Priority:** `rst` > `death` (any non-DEAD state → DEAD, position frozen) > fall-out > landing/ceiling > jump/gap.

## Timing
- All outputs are registered. A tick's inputs are reflected in the outputs after that edge (latency 1).
- `airborne`, `dead` and `pstate` are decoded from the state register, so they change on the same edge as the state.
- `fell` is high for exactly one cycle, on the same edge DEAD is entered.
- The jump arc is deterministic: RISE lasts JUMP_V ticks, apex = FLOOR_Y − JUMP_V(JUMP_V+1)/2.
- `rst` mid-jump or mid-DEAD returns all reset values on the next edge.

## Structure
- Package `player_pkg` holds:
  - the `pstate_t` enum (GROUND, RISE, FALL, DEAD)
  - the parameter defaults as localparams
  - a 4-bit velocity type
- Sub-module `btn_edge`: a one-register rising-edge detector, used for `up`.
- Core: one state register, vel register, dead counter, and x/y next-state logic. Target roughly 200 lines.

## Test plan
- **Reset/idle:** `rst` 1 tick, no buttons for 10 ticks → x=320, y=400, pstate=0, `airborne`=0, `dead`=0, `fell`=0 throughout.
- **Left clamp:** hold `left` → x steps 320, 318, … and reaches 10 after 155 ticks, then stays 10. Hold `left`+`right` → x unchanged.
- **Jump:** single `up` pulse → y=388, 377, … reaching apex 322 after 12 ticks, then FALL. Lands at y=400, GROUND within 14 fall ticks. Holding `up` afterwards causes no second jump.
- **Ceiling:** Y_MIN=350 → y=388, 377, 367, 358, 350, then clamps at 350 and enters FALL with vel=1.
- **Pit:** `floor_gap`=1 in GROUND → falls 401, 403, 406, …, reaches 479 on fall tick 14 with `fell` pulsed for one cycle, DEAD for 64 ticks, then respawns at x=320, y=400.
- **Death mid-jump:** `death` asserted on rise tick 3 (same tick as `left`) → position frozen at y=367, x unchanged, `dead`=1. Respawn at x=320, y=400 after 64 ticks. `rst` during DEAD → reset values on the next edge.
